// File: rtl/stack_queue_if.sv
// stack_queue_if: producer/consumer bundle for stack_queue; master drives requests, slave returns data, occupancy and status
interface stack_queue_if #(
  parameter int data_width = 8,
  parameter int depth = 8
);
  localparam int cw = $clog2(depth + 1);
  logic push;
  logic pop;
  logic mode;
  logic err_clr;
  logic [data_width-1:0] data_in;
  logic [data_width-1:0] data_out;
  logic out_valid;
  logic [cw-1:0] count;
  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  logic overflow;
  logic underflow;
  logic mode_active;
  modport master (
    output push, pop, mode, err_clr, data_in,
    input data_out, out_valid, count, full, empty, almost_full, almost_empty,
    overflow, underflow, mode_active
  );
  modport slave (
    input push, pop, mode, err_clr, data_in,
    output data_out, out_valid, count, full, empty, almost_full, almost_empty,
    overflow, underflow, mode_active
  );
endinterface

// File: rtl/stack_queue.sv
// stack_queue: run-time selectable LIFO/FIFO buffer; ports clk, rst (async active-high) and bus (stack_queue_if.slave)
module stack_queue #(
  parameter int data_width = 8,
  parameter int depth = 8,
  parameter int af_level = 6,
  parameter int ae_level = 2
) (
  input logic clk,
  input logic rst,
  stack_queue_if.slave bus
);
  localparam int cw = $clog2(depth + 1);
  localparam int aw = $clog2(depth);
  logic [data_width-1:0] mem [depth];
  logic [data_width-1:0] dout;
  logic [cw-1:0] cnt, cnt_nxt;
  logic [aw-1:0] wr_ptr, rd_ptr, top, wa, ra;
  logic push_ok, pop_ok, full, empty, vld, ovf, unf, mode_q;
  function automatic logic [aw-1:0] inc(input logic [aw-1:0] p);
    return (p == aw'(depth - 1)) ? '0 : p + 1'b1;
  endfunction
  assign full = cnt == cw'(depth);
  assign empty = cnt == '0;
  // LIFO addresses through the count: push+pop overwrites the old top in place
  always_comb begin
    pop_ok = bus.pop && !empty;
    push_ok = bus.push && (!full || pop_ok);
    top = aw'(cnt - 1'b1);
    wa = mode_q ? wr_ptr : (pop_ok ? top : aw'(cnt));
    ra = mode_q ? rd_ptr : top;
    cnt_nxt = cnt + cw'(push_ok) - cw'(pop_ok);
  end
  always_ff @(posedge clk)
    if (push_ok) mem[wa] <= bus.data_in;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout <= '0;
      vld <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      vld <= pop_ok;
      if (pop_ok) dout <= mem[ra];
      if (cnt_nxt == '0) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else if (mode_q) begin
        if (push_ok) wr_ptr <= inc(wr_ptr);
        if (pop_ok) rd_ptr <= inc(rd_ptr);
      end
      // mode can only change while nothing is stored, so data is never reinterpreted
      if (empty && !push_ok) mode_q <= bus.mode;
      ovf <= (bus.push && !push_ok) || (ovf && !bus.err_clr);
      unf <= (bus.pop && !pop_ok) || (unf && !bus.err_clr);
    end
  assign bus.data_out = dout;
  assign bus.out_valid = vld;
  assign bus.count = cnt;
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.almost_full = cnt >= cw'(af_level);
  assign bus.almost_empty = cnt <= cw'(ae_level);
  assign bus.overflow = ovf;
  assign bus.underflow = unf;
  assign bus.mode_active = mode_q;
endmodule
